eight_bit_piso_serializer: RTL and testbench

Parallel-in, serial-out serializer: the transmit end of the 8-bit serial link whose receive end is our serial-in shift register. It accepts a parallel word through a valid/ready handshake and drives it out one bit per clock, with a frame-valid qualifier and an end-of-word pulse. With MSB_FIRST=1 the word lands unchanged in a downstream receiver that shifts into bit 0 and moves toward bit 7. Back-to-back words stream with no idle gap.

---
 rtl/eight_bit_piso_serializer.sv | 129 ++++++++++++
 tb/tb_eight_bit_piso_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : eight_bit_piso_serializer
//  Description : Parallel-in, serial-out serializer. A word offered with
//                load_valid is taken when load_ready is high and is driven
//                out one bit per clock on shift_out, qualified by
//                shift_valid. done pulses together with the last bit. A new
//                word may be taken on the last-bit edge, so consecutive
//                words stream with no idle gap.
//  Ports       : clk         - clock, rising edge
//                rst         - synchronous active-high reset
//                load_valid  - load_data is presented this cycle
//                load_data   - parallel word, sampled only on accept
//                load_ready  - a word can be taken this cycle (combinational)
//                shift_out   - serial data bit (registered)
//                shift_valid - shift_out carries a frame bit (registered)
//                done        - pulse coincident with the last bit (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             shift_out,
    output logic             shift_valid,
    output logic             done
);

    localparam int                 c_cnt_w  = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_shift_out;
    logic               r_shift_valid;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_accept;
    logic               w_out_bit_nxt;

    // Ready in IDLE and on the last bit of a frame, so the next word can be
    // taken on the closing edge without a bubble. In IDLE r_cnt is 0, which
    // never equals c_last because WIDTH is at least 2.
    assign load_ready = !rst && ((r_state == ST_IDLE) || (r_cnt == c_last));
    assign w_accept   = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_sreg_nxt  = load_data;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_last) begin
                    if (w_accept) begin
                        w_sreg_nxt = load_data;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_sreg_nxt  = '0;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    // Shift toward the output end, filling with zeros.
                    if (MSB_FIRST) begin
                        w_sreg_nxt = {r_sreg[WIDTH-2:0], 1'b0};
                    end else begin
                        w_sreg_nxt = {1'b0, r_sreg[WIDTH-1:1]};
                    end
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sreg_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The registered outputs are computed from the next-state values so that
    // they describe the cycle the new state belongs to.
    assign w_out_bit_nxt = MSB_FIRST ? w_sreg_nxt[WIDTH-1] : w_sreg_nxt[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sreg        <= '0;
            r_cnt         <= '0;
            r_shift_out   <= 1'b0;
            r_shift_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sreg        <= w_sreg_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shift_out   <= (w_state_nxt == ST_SHIFT) && w_out_bit_nxt;
            r_shift_valid <= (w_state_nxt == ST_SHIFT);
            r_done        <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == c_last);
        end
    end

    assign shift_out   = r_shift_out;
    assign shift_valid = r_shift_valid;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eight_bit_piso_serializer
//  Description : Directed self-checking bench for eight_bit_piso_serializer.
//                One MSB-first instance with a looped-back receive shift
//                register, and one LSB-first instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eight_bit_piso_serializer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       shift_out;
    logic       shift_valid;
    logic       done;

    logic       lsb_load_valid;
    logic [7:0] lsb_load_data;
    logic       lsb_load_ready;
    logic       lsb_shift_out;
    logic       lsb_shift_valid;
    logic       lsb_done;

    logic [7:0] r_rx;

    int checks;
    int errors;

    eight_bit_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .shift_out   (shift_out),
        .shift_valid (shift_valid),
        .done        (done)
    );

    eight_bit_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (lsb_load_valid),
        .load_data   (lsb_load_data),
        .load_ready  (lsb_load_ready),
        .shift_out   (lsb_shift_out),
        .shift_valid (lsb_shift_valid),
        .done        (lsb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream receiver: shifts into bit 0 while shift_valid is high.
    always_ff @(posedge clk) begin
        if (shift_valid) r_rx <= {r_rx[6:0], shift_out};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(shift_valid), 32'd0);
        chk({tag, "_out"},   32'(shift_out),   32'd0);
        chk({tag, "_done"},  32'(done),        32'd0);
    endtask

    // Send one word on the MSB-first instance and check every bit.
    task automatic send_word(input logic [7:0] word);
        chk("sw_ready_pre", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = word;
        tick();
        load_valid = 1'b0;
        load_data  = 8'h00;
        for (int j = 0; j < 8; j++) begin
            chk("sw_bit",   32'(shift_out),   32'(word[7-j]));
            chk("sw_valid", 32'(shift_valid), 32'd1);
            chk("sw_done",  32'(done),        32'(j == 7));
            chk("sw_ready", 32'(load_ready),  32'(j == 7));
            tick();
        end
        chk_idle("sw_after");
        chk("sw_rx", 32'(r_rx), 32'(word));
    endtask

    // Two words in a row; the second is offered from cycle `start` of the
    // first frame and must only be taken on its last-bit edge.
    task automatic stream2(input logic [7:0] first, input logic [7:0] second, input int start);
        logic [15:0] exp_bits;
        exp_bits   = {first, second};
        load_valid = 1'b1;
        load_data  = first;
        tick();
        load_data  = second;
        for (int c = 0; c < 16; c++) begin
            if (c >= start && c <= 7) load_valid = 1'b1;
            else load_valid = 1'b0;
            #1;
            chk("st_bit",   32'(shift_out),   32'(exp_bits[15-c]));
            chk("st_valid", 32'(shift_valid), 32'd1);
            chk("st_done",  32'(done),        32'((c % 8) == 7));
            chk("st_ready", 32'(load_ready),  32'((c % 8) == 7));
            tick();
        end
        load_data = 8'h00;
        chk_idle("st_after");
        chk("st_ready_idle", 32'(load_ready), 32'd1);
        chk("st_rx", 32'(r_rx), 32'(second));
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        load_valid     = 1'b0;
        load_data      = 8'h00;
        lsb_load_valid = 1'b0;
        lsb_load_data  = 8'h00;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_ready", 32'(load_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(load_ready), 32'd1);

        // Idle hold.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
            chk("idle_ready", 32'(load_ready), 32'd1);
        end

        // Single word.
        send_word(8'hA5);

        // Back-to-back.
        stream2(8'hA5, 8'h3C, 0);

        // Busy rejection.
        stream2(8'h00, 8'hFF, 1);

        // LSB-first instance.
        lsb_load_valid = 1'b1;
        lsb_load_data  = 8'h01;
        tick();
        lsb_load_valid = 1'b0;
        lsb_load_data  = 8'h00;
        for (int j = 0; j < 8; j++) begin
            chk("lsb_bit",   32'(lsb_shift_out),   32'(j == 0));
            chk("lsb_valid", 32'(lsb_shift_valid), 32'd1);
            chk("lsb_done",  32'(lsb_done),        32'(j == 7));
            tick();
        end
        chk("lsb_after", 32'(lsb_shift_valid), 32'd0);

        // Reset during bit 3 of 8'hA5, with a load offered under reset.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        tick();
        load_valid = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        chk("mr_bit3", 32'(shift_out), 32'd0);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        #1;
        chk("mr_ready_rst", 32'(load_ready), 32'd0);
        tick();
        chk_idle("mr");
        chk("mr_ready_rst2", 32'(load_ready), 32'd0);
        rst        = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("mr_ready_rel", 32'(load_ready), 32'd1);
        tick();
        chk_idle("mr_noload");
        send_word(8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
